// File: rtl/io_pad_pwr_pkg.sv
// Shared types and default sizing for the IO pad-ring power sequencer.
package io_pad_pwr_pkg;

  localparam int unsigned N_BANK_DEF      = 4;
  localparam int unsigned DLY_W_DEF       = 8;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    WAIT_SUP = 3'd1,
    UP_DRV   = 3'd2,
    UP_NEXT  = 3'd3,
    ON       = 3'd4,
    DN_ISO   = 3'd5,
    DN_NEXT  = 3'd6,
    FAULT    = 3'd7
  } state_t;

endpackage

// File: rtl/io_pad_pwr_seq_sync.sv
// Multi-stage synchronizer for a single asynchronous level (supply-good flag).
module io_sync_ff
  import io_pad_pwr_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // shift the asynchronous level through the flop chain; reset reads as "supply bad"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/io_pad_pwr_seq.sv
// IO pad-ring power sequencer: debounces VDDIO-good, releases isolation and
// enables drivers bank by bank on power-up, unwinds in reverse on power-down,
// and clamps every bank at once when the supply disappears.
module io_pad_pwr_seq
  import io_pad_pwr_pkg::*;
#(
  parameter int unsigned N_BANK      = N_BANK_DEF,
  parameter int unsigned DLY_W       = DLY_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vddio_ok_i,
  input  logic              pwr_req_i,
  input  logic [DLY_W-1:0]  dly_cfg_i,
  output logic [N_BANK-1:0] iso_n_o,
  output logic [N_BANK-1:0] oe_en_o,
  output logic              busy_o,
  output logic              pwr_ok_o,
  output logic              err_o
);

  localparam int unsigned BANK_W = (N_BANK > 1) ? $clog2(N_BANK) : 1;

  state_t              state, state_nxt;
  logic [DLY_W-1:0]    cnt, cnt_nxt;
  logic [BANK_W-1:0]   bank, bank_nxt;
  logic [N_BANK-1:0]   iso_q, iso_nxt;
  logic [N_BANK-1:0]   oe_q, oe_nxt;
  logic                vs;
  logic                cnt_zero;
  logic                last_bank;

  io_sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_vddio_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (vddio_ok_i),
    .q     (vs)
  );

  assign cnt_zero  = (cnt == '0);
  assign last_bank = (bank == BANK_W'(N_BANK - 1));

  // state, step counter, bank index and pad-control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OFF;
      cnt   <= '0;
      bank  <= '0;
      iso_q <= '0;
      oe_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      bank  <= bank_nxt;
      iso_q <= iso_nxt;
      oe_q  <= oe_nxt;
    end
  end

  // next-state and pad-control decisions; supply loss outranks every other event
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_zero ? cnt : cnt - DLY_W'(1);
    bank_nxt  = bank;
    iso_nxt   = iso_q;
    oe_nxt    = oe_q;

    unique case (state)
      OFF: begin
        if (pwr_req_i && vs) begin
          state_nxt = WAIT_SUP;
          cnt_nxt   = dly_cfg_i;
        end
      end

      WAIT_SUP: begin
        if (!pwr_req_i) begin
          state_nxt = OFF;
        end else if (!vs) begin
          cnt_nxt = dly_cfg_i;
        end else if (cnt_zero) begin
          iso_nxt[0] = 1'b1;
          bank_nxt   = '0;
          state_nxt  = UP_DRV;
          cnt_nxt    = dly_cfg_i;
        end
      end

      UP_DRV: begin
        if (!vs) begin
          state_nxt = FAULT;
          iso_nxt   = '0;
          oe_nxt    = '0;
          cnt_nxt   = '0;
        end else if (!pwr_req_i) begin
          // driver of this bank is not yet on, so unwinding starts at its isolation
          state_nxt = DN_ISO;
          cnt_nxt   = dly_cfg_i;
        end else if (cnt_zero) begin
          oe_nxt[bank] = 1'b1;
          state_nxt    = UP_NEXT;
          cnt_nxt      = dly_cfg_i;
        end
      end

      UP_NEXT: begin
        if (!vs) begin
          state_nxt = FAULT;
          iso_nxt   = '0;
          oe_nxt    = '0;
          cnt_nxt   = '0;
        end else if (!pwr_req_i) begin
          oe_nxt[bank] = 1'b0;
          state_nxt    = DN_ISO;
          cnt_nxt      = dly_cfg_i;
        end else if (cnt_zero) begin
          if (last_bank) begin
            state_nxt = ON;
          end else begin
            bank_nxt          = bank + BANK_W'(1);
            iso_nxt[bank_nxt] = 1'b1;
            state_nxt         = UP_DRV;
            cnt_nxt           = dly_cfg_i;
          end
        end
      end

      ON: begin
        if (!vs) begin
          state_nxt = FAULT;
          iso_nxt   = '0;
          oe_nxt    = '0;
          cnt_nxt   = '0;
        end else if (!pwr_req_i) begin
          oe_nxt[N_BANK-1] = 1'b0;
          bank_nxt         = BANK_W'(N_BANK - 1);
          state_nxt        = DN_ISO;
          cnt_nxt          = dly_cfg_i;
        end
      end

      DN_ISO: begin
        if (!vs) begin
          state_nxt = FAULT;
          iso_nxt   = '0;
          oe_nxt    = '0;
          cnt_nxt   = '0;
        end else if (cnt_zero) begin
          iso_nxt[bank] = 1'b0;
          state_nxt     = DN_NEXT;
          cnt_nxt       = dly_cfg_i;
        end
      end

      DN_NEXT: begin
        if (!vs) begin
          state_nxt = FAULT;
          iso_nxt   = '0;
          oe_nxt    = '0;
          cnt_nxt   = '0;
        end else if (cnt_zero) begin
          if (bank == '0) begin
            state_nxt = OFF;
          end else begin
            bank_nxt         = bank - BANK_W'(1);
            oe_nxt[bank_nxt] = 1'b0;
            state_nxt        = DN_ISO;
            cnt_nxt          = dly_cfg_i;
          end
        end
      end

      FAULT: begin
        if (!pwr_req_i) begin
          state_nxt = OFF;
        end
      end

      default: begin
        state_nxt = OFF;
        iso_nxt   = '0;
        oe_nxt    = '0;
      end
    endcase
  end

  assign iso_n_o  = iso_q;
  assign oe_en_o  = oe_q;
  assign busy_o   = !(state inside {OFF, ON, FAULT});
  assign pwr_ok_o = (state == ON);
  assign err_o    = (state == FAULT);

  // a driver may never be enabled on a bank that is still isolated
  a_oe_needs_iso: assert property (@(posedge clk) disable iff (!rst_n)
    ((oe_en_o & ~iso_n_o) == '0));

endmodule

// File: doc/io_pad_pwr_seq.md
Name: io_pad_pwr_seq

Overview:
- Sequences power-up and power-down of the IO pad ring in N_BANK pad banks, each built from EG1D80V IO cells with VPW/VDDIO/VDD supply pins.
- Waits for a debounced VDDIO-good indication, then releases isolation and enables output drivers bank by bank with a programmable step delay to limit inrush current.
- Unwinds the sequence in reverse on power-down.
- Forces safe pad state immediately on supply loss.
- Sits in the always-on domain between the PMU and the pad-ring control inputs.

Parameters:
- N_BANK, 4, number of pad banks sequenced; index 0 is first up and last down.
- DLY_W, 8, width of the step-delay configuration and counter.
- SYNC_STAGES, 2, flop stages on the asynchronous vddio_ok_i input (minimum 2).

Ports:
- clk  input  1  always-on sequencer clock.
- rst_n  input  1  asynchronous active-low reset.
- vddio_ok_i  input  1  VDDIO supply-good from analog detector; asynchronous to clk.
- pwr_req_i  input  1  level request, synchronous to clk: 1 = pad ring on, 0 = off.
- dly_cfg_i  input  DLY_W  step delay; each step waits dly_cfg_i+1 cycles; sampled at each counter load.
- iso_n_o  output  N_BANK  per-bank isolation release; 0 = isolated/clamped.
- oe_en_o  output  N_BANK  per-bank output-driver enable.
- busy_o  output  1  1 in any state other than OFF, ON, FAULT.
- pwr_ok_o  output  1  1 only in ON.
- err_o  output  1  sticky supply-loss flag; 1 only in FAULT.

Behaviour:
- Reset: state OFF, counter 0, bank index 0, synchronizer flops 0, all outputs 0. Assert reset immediately; deassert synchronously (external reset sync).
- vs = synchronized vddio_ok_i, SYNC_STAGES cycles of latency. All decisions use vs.
- Counter: load dly_cfg_i on entry to a wait; decrement each cycle. An action occurs on the edge after the cycle where cnt==0, so consecutive actions are exactly dly_cfg_i+1 cycles apart. dly_cfg_i=0 gives 1 cycle. No wrap: the counter only decrements while nonzero.
- OFF: if pwr_req_i & vs, go to WAIT_SUP and load counter. Otherwise stay.
- WAIT_SUP (debounce):
  - vs=0 reloads the counter.
  - pwr_req_i=0 returns to OFF.
  - cnt==0 with vs=1: set iso_n_o[0]=1, bank=0, go to UP_DRV, load counter.
- UP_DRV: at cnt==0, set oe_en_o[bank]=1, go to UP_NEXT, load counter.
- UP_NEXT: at cnt==0:
  - if bank==N_BANK-1, go to ON;
  - else bank++, set iso_n_o[bank]=1, go to UP_DRV, load counter.
- ON: pwr_ok_o=1. When pwr_req_i falls, clear oe_en_o[N_BANK-1], bank=N_BANK-1, go to DN_ISO, load counter.
- DN_ISO: at cnt==0, clear iso_n_o[bank], go to DN_NEXT, load counter.
- DN_NEXT: at cnt==0:
  - if bank==0, go to OFF;
  - else bank--, clear oe_en_o[bank], go to DN_ISO, load counter.
- pwr_req_i falls during UP_DRV/UP_NEXT: on the next cycle enter the down path at the current bank.
  - If oe_en_o[bank]=1, clear it and go to DN_ISO.
  - Else go to DN_ISO immediately.
  - Never enable a new bank after the request drops.
- pwr_req_i rises during the down path: ignored. Complete to OFF, then restart from OFF on the following cycle.
- Supply loss: vs=0 in any of UP_DRV, UP_NEXT, ON or the down states takes priority over everything.
  - Next edge: all oe_en_o=0 and all iso_n_o=0 simultaneously, err_o=1, state FAULT.
  - Leave FAULT only when pwr_req_i=0, to OFF; err_o clears on that edge.
- Invariant, checked by assertion: oe_en_o[b]=1 implies iso_n_o[b]=1.

Decomposition:
- Package io_pad_pwr_pkg: state enum (OFF, WAIT_SUP, UP_DRV, UP_NEXT, ON, DN_ISO, DN_NEXT, FAULT) and default parameter constants.
- Sub-module io_sync_ff: SYNC_STAGES-deep synchronizer with async active-low reset to 0, used for vddio_ok_i.
- FSM, counter and bank index stay in the top module.

Test Plan:
- N_BANK=2, dly_cfg=3, vs=1, pwr_req rises at cycle 0 → iso_n[0]=1 at cycle 5, oe[0] at 9, iso_n[1] at 13, oe[1] at 17, pwr_ok at 21; busy high from cycle 1 to 20.
- From ON, pwr_req falls → oe[1]=0 next edge, then iso_n[1]=0 +4, oe[0]=0 +8, iso_n[0]=0 +12, OFF/busy=0 +16.
- vddio_ok glitches low for 2 cycles during WAIT_SUP with dly_cfg=3 → debounce restarts; iso_n[0] asserts 4 cycles after vs returns high.
- vddio_ok drops in ON → after SYNC_STAGES+1 edges all oe/iso_n=0 and err_o=1; pwr_req=0 → OFF, err_o=0; pwr_req=1 → full sequence repeats.
- pwr_req falls one cycle after iso_n[1] rises (oe[1]=0) → oe[1] never asserts, iso_n[1] clears 4 cycles later, down path completes; invariant holds throughout.
- dly_cfg=0, and rst_n asserted mid UP_DRV → 1-cycle step spacing; reset forces all outputs 0 asynchronously, and the block resumes from OFF.
